pipeline_hazard_controller: RTL

Central stall/flush sequencer for the five-stage pipeline (fetch, decode, execute, memory, write-back).
- Detects load-use hazards and inserts bubbles.
- Squashes wrong-path instructions when a branch or jump resolves in the memory stage.
- Freezes the pipeline while data memory reports busy.
- Provides a halt/drain handshake for debug and test.

It drives the write-enable and flush controls of the PC and the four pipeline registers, and keeps saturating stall and flush event counters.

---
 rtl/pipeline_hazard_controller.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_controller
//  Brief    : Stall/flush sequencer for a five-stage pipeline. It handles
//             load-use bubbles, wrong-path squash on redirect, and freezing
//             on data-memory busy. It also runs a halt/drain handshake and
//             keeps saturating stall and flush counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int DRAIN_CYCLES  = 4,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [4:0]               decodeRs1,
    input  logic [4:0]               decodeRs2,
    input  logic                     decodeUsesRs1,
    input  logic                     decodeUsesRs2,
    input  logic [4:0]               executeRd,
    input  logic                     executeMemoryRead,
    input  logic                     redirect,
    input  logic                     memoryBusy,
    input  logic                     haltRequest,
    output logic                     pcWriteEnable,
    output logic                     fetchToDecodeWriteEnable,
    output logic                     fetchToDecodeFlush,
    output logic                     decodeToExecuteWriteEnable,
    output logic                     decodeToExecuteFlush,
    output logic                     executeToMemoryWriteEnable,
    output logic                     executeToMemoryFlush,
    output logic                     memoryToWriteBackFlush,
    output logic                     halted,
    output logic [1:0]               controllerState,
    output logic [COUNTER_WIDTH-1:0] stallCycles,
    output logic [COUNTER_WIDTH-1:0] flushCount
);

    localparam logic [1:0] c_RUN      = 2'd0;
    localparam logic [1:0] c_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_DRAIN    = 2'd2;
    localparam logic [1:0] c_HALTED   = 2'd3;

    localparam int c_DRAIN_WIDTH = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_DRAIN_WIDTH-1:0] c_DRAIN_LOAD = c_DRAIN_WIDTH'(DRAIN_CYCLES - 1);

    logic [1:0]               r_state;
    logic [1:0]               w_nextState;
    logic [c_DRAIN_WIDTH-1:0] r_drainCount;
    logic [c_DRAIN_WIDTH-1:0] w_nextDrainCount;
    logic [COUNTER_WIDTH-1:0] r_stallCycles;
    logic [COUNTER_WIDTH-1:0] r_flushCount;
    logic                     r_halted;
    logic                     w_loadUse;
    logic                     w_acceptRedirect;
    logic                     w_stallCycle;

    assign w_loadUse = executeMemoryRead && (executeRd != 5'd0) &&
                       (((executeRd == decodeRs1) && decodeUsesRs1) ||
                        ((executeRd == decodeRs2) && decodeUsesRs2));

    // Redirects are not accepted while memory is busy or while halted.
    assign w_acceptRedirect = redirect && !memoryBusy && (r_state != c_HALTED);

    // PC holds in RUN/MEM_WAIT are stalls; drain holds are intentional and not counted.
    assign w_stallCycle = !pcWriteEnable && ((r_state == c_RUN) || (r_state == c_MEM_WAIT));

    assign controllerState = r_state;
    assign halted          = r_halted;
    assign stallCycles     = r_stallCycles;
    assign flushCount      = r_flushCount;

    // Pipeline register controls in priority order: halted, busy, redirect, load-use, drain.
    always_comb begin
        pcWriteEnable              = 1'b1;
        fetchToDecodeWriteEnable   = 1'b1;
        fetchToDecodeFlush         = 1'b0;
        decodeToExecuteWriteEnable = 1'b1;
        decodeToExecuteFlush       = 1'b0;
        executeToMemoryWriteEnable = 1'b1;
        executeToMemoryFlush       = 1'b0;
        memoryToWriteBackFlush     = 1'b0;
        if (r_state == c_HALTED) begin
            pcWriteEnable      = 1'b0;
            fetchToDecodeFlush = 1'b1;
        end else if (memoryBusy) begin
            pcWriteEnable              = 1'b0;
            fetchToDecodeWriteEnable   = 1'b0;
            decodeToExecuteWriteEnable = 1'b0;
            executeToMemoryWriteEnable = 1'b0;
            memoryToWriteBackFlush     = 1'b1;
        end else if (redirect) begin
            fetchToDecodeFlush   = 1'b1;
            decodeToExecuteFlush = 1'b1;
            executeToMemoryFlush = 1'b1;
        end else if (w_loadUse) begin
            pcWriteEnable            = 1'b0;
            fetchToDecodeWriteEnable = 1'b0;
            decodeToExecuteFlush     = 1'b1;
        end else if (r_state == c_DRAIN) begin
            // PC holds so the squashed fetch is refetched on resume.
            pcWriteEnable      = 1'b0;
            fetchToDecodeFlush = 1'b1;
        end
    end

    // Next state and drain countdown.
    always_comb begin
        w_nextState      = r_state;
        w_nextDrainCount = r_drainCount;
        case (r_state)
            c_RUN: begin
                if (memoryBusy) begin
                    w_nextState = c_MEM_WAIT;
                end else if (haltRequest) begin
                    w_nextState      = c_DRAIN;
                    w_nextDrainCount = c_DRAIN_LOAD;
                end
            end
            c_MEM_WAIT: begin
                if (!memoryBusy) begin
                    if (haltRequest) begin
                        w_nextState      = c_DRAIN;
                        w_nextDrainCount = c_DRAIN_LOAD;
                    end else begin
                        w_nextState = c_RUN;
                    end
                end
            end
            c_DRAIN: begin
                if (!haltRequest) begin
                    w_nextState = memoryBusy ? c_MEM_WAIT : c_RUN;
                end else if (memoryBusy) begin
                    w_nextState = c_DRAIN;
                end else if (r_drainCount == '0) begin
                    w_nextState = c_HALTED;
                end else if (!(w_loadUse && !redirect)) begin
                    w_nextDrainCount = r_drainCount - c_DRAIN_WIDTH'(1);
                end
            end
            c_HALTED: begin
                if (!haltRequest) begin
                    w_nextState = c_RUN;
                end
            end
            default: begin
                w_nextState = c_RUN;
            end
        endcase
    end

    // State, drain count, halted flag and saturating event counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= c_RUN;
            r_drainCount  <= '0;
            r_stallCycles <= '0;
            r_flushCount  <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_drainCount <= w_nextDrainCount;
            r_halted     <= (w_nextState == c_HALTED);
            if (w_stallCycle && !(&r_stallCycles)) begin
                r_stallCycles <= r_stallCycles + COUNTER_WIDTH'(1);
            end
            if (w_acceptRedirect && !(&r_flushCount)) begin
                r_flushCount <= r_flushCount + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire
